// File: rtl/ws2812b_chain_if.sv
// Bus bundle for the WS2812B chain driver: colour-store write port, frame
// request, and the status/serial outputs.
interface ws2812b_chain_if #(
   parameter int AW = 3
);
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [23:0]   wr_data;
   logic          show;
   logic          busy;
   logic          frame_done;
   logic          dout;

   // Controller side: writes colours, requests frames, watches status.
   modport master (
      output wr_en, wr_addr, wr_data, show,
      input  busy, frame_done, dout
   );

   // Driver side.
   modport slave (
      input  wr_en, wr_addr, wr_data, show,
      output busy, frame_done, dout
   );
endinterface

// File: rtl/ws2812b_chain.sv
// WS2812B driver for a daisy chain of NUM_LEDS pixels with a per-pixel GRB
// colour store. Frames go out MSB first, pixel 0 first, followed by a low
// latch gap. Frames start on a show request or repeat in auto-refresh mode.
module ws2812b_chain #(
   parameter int          CLOCK_MHZ    = 27,
   parameter int          NUM_LEDS     = 8,
   parameter int          T0H_NS       = 400,
   parameter int          T1H_NS       = 800,
   parameter int          BIT_NS       = 1250,
   parameter int          RESET_US     = 80,
   parameter logic [23:0] INIT_COLOR   = 24'h000505,
   parameter bit          AUTO_REFRESH = 1'b0
) (
   input  logic           clk,
   input  logic           rst_n,
   ws2812b_chain_if.slave bus
);

   localparam int AW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int T0H_CYC = CLOCK_MHZ * T0H_NS / 1000;
   localparam int T1H_CYC = CLOCK_MHZ * T1H_NS / 1000;
   localparam int BIT_CYC = CLOCK_MHZ * BIT_NS / 1000;
   localparam int RST_CYC = CLOCK_MHZ * RESET_US;
   localparam int MAX_CYC = (RST_CYC > BIT_CYC) ? RST_CYC : BIT_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);

   // Terminal counts, pre-sized to the counter width.
   localparam logic [CW-1:0] T0H_LAST   = CW'(T0H_CYC - 1);
   localparam logic [CW-1:0] T1H_LAST   = CW'(T1H_CYC - 1);
   localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYC - 1);
   localparam logic [CW-1:0] RST_PENULT = CW'((RST_CYC > 1) ? RST_CYC - 2 : 0);
   localparam logic [AW-1:0] LAST_PIX   = AW'(NUM_LEDS - 1);
   localparam logic [AW:0]   NUM_LEDS_W = (AW + 1)'(NUM_LEDS);

   typedef enum logic [1:0] {IDLE, BIT_HI, BIT_LO, GAP} state_t;

   logic [23:0]   store [NUM_LEDS];
   state_t        state;
   logic [CW-1:0] cnt;        // cycles into the current bit, or into the gap
   logic [4:0]    bit_idx;    // bit of the current pixel now on the wire
   logic [AW-1:0] pix;        // pixel now on the wire
   logic [23:0]   shreg;      // current pixel, MSB is the bit being sent
   logic          show_q;
   logic          pending;
   logic          start;
   logic [AW-1:0] pix_next;

   assign start    = show_q | pending | AUTO_REFRESH;
   assign pix_next = pix + AW'(1);

   // Colour store: in-range writes accepted at any time, including mid-frame.
   // NOTE: the store is a bank of flops that must hold INIT_COLOR after reset,
   // so it is reset like any other register rather than treated as a RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LEDS; i++) store[i] <= INIT_COLOR;
      end else if (bus.wr_en && ({1'b0, bus.wr_addr} < NUM_LEDS_W)) begin
         store[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Show request is registered once before the frame machine looks at it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) show_q <= 1'b0;
      else        show_q <= bus.show;
   end

   // Frame machine: bit timing, pixel sequencing, latch gap, request queueing.
   // NOTE: every register here uses <= so all branches see the pre-edge
   // values; that is also what makes a same-cycle write and pixel load
   // return the old colour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         bit_idx        <= '0;
         pix            <= '0;
         shreg          <= '0;
         pending        <= 1'b0;
         bus.busy       <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.dout       <= 1'b0;
      end else begin
         bus.frame_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state    <= BIT_HI;
                  pix      <= '0;
                  shreg    <= store[0];
                  bit_idx  <= 5'd23;
                  cnt      <= '0;
                  pending  <= 1'b0;
                  bus.dout <= 1'b1;
                  bus.busy <= 1'b1;
               end
            end
            BIT_HI: begin
               cnt <= cnt + CW'(1);
               if (cnt == (shreg[23] ? T1H_LAST : T0H_LAST)) begin
                  state    <= BIT_LO;
                  bus.dout <= 1'b0;
               end
            end
            BIT_LO: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (bit_idx != 5'd0) begin
                     bit_idx  <= bit_idx - 5'd1;
                     shreg    <= {shreg[22:0], 1'b0};
                     state    <= BIT_HI;
                     bus.dout <= 1'b1;
                  end else if (pix != LAST_PIX) begin
                     // Next pixel loads here so its first bit follows seamlessly.
                     pix      <= pix_next;
                     shreg    <= store[pix_next];
                     bit_idx  <= 5'd23;
                     state    <= BIT_HI;
                     bus.dout <= 1'b1;
                  end else begin
                     state          <= GAP;
                     bus.frame_done <= (RST_CYC == 1);
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            GAP: begin
               if (cnt == RST_LAST) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end else begin
                  cnt            <= cnt + CW'(1);
                  bus.frame_done <= (RST_CYC > 1) && (cnt == RST_PENULT);
               end
            end
         endcase
         // A request arriving mid-frame is held for the next IDLE cycle.
         if (state != IDLE && show_q) pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ws2812b_chain.sv
// Bench for ws2812b_chain: a 2-pixel manual-show instance checked pulse by
// pulse against a scoreboard, and a 3-pixel auto-refresh instance checked
// frame by frame against a colour model.
module tb_ws2812b_chain;

   localparam int T0H  = 10;
   localparam int T1H  = 21;
   localparam int BITC = 33;
   localparam int RSTC = 2160;
   localparam int FRAME_A = 2 * 24 * BITC + RSTC;   // 3744
   localparam int FRAME_B = 3 * 24 * BITC + RSTC;   // 4536
   localparam logic [23:0] INIT = 24'h000505;

   typedef struct { int hi; int lo; } pulse_t;
   typedef struct { logic [23:0] p0; logic [23:0] p1; int ones; } vec_t;

   logic clk = 1'b0;
   logic rst_a_n = 1'b0;
   logic rst_b_n = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_miss = 0;

   ws2812b_chain_if #(.AW(1)) a_if ();
   ws2812b_chain_if #(.AW(2)) b_if ();

   ws2812b_chain #(.NUM_LEDS(2), .AUTO_REFRESH(1'b0)) dut_a (
      .clk(clk), .rst_n(rst_a_n), .bus(a_if)
   );
   ws2812b_chain #(.NUM_LEDS(3), .AUTO_REFRESH(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_b_n), .bus(b_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- scoreboard for instance A ----------------
   pulse_t      exp_q[$];
   logic [23:0] a_model [2];

   task automatic push_pixel(input logic [23:0] d, input bit last);
      for (int b = 23; b >= 0; b--) begin
         pulse_t p;
         p.hi = d[b] ? T1H : T0H;
         p.lo = BITC - p.hi;
         if (last && b == 0) p.lo += RSTC;
         exp_q.push_back(p);
      end
   endtask

   int a_hi, a_lo, a_frame_len, a_ones, a_frames = 0, a_rise_cyc, a_idle, a_last_idle = -1;
   bit a_in_pulse, a_in_hi, a_in_frame, a_gap_track, a_prev_done;

   task automatic end_pulse_a();
      if (exp_q.size() == 0) begin
         check("a_unexpected_pulse", 1, 0);
      end else begin
         pulse_t e;
         e = exp_q.pop_front();
         check("a_pulse_hi", a_hi, e.hi);
         check("a_pulse_lo", a_lo, e.lo);
      end
      if (a_hi == T1H) a_ones++;
   endtask

   // Measure A's pulses, frame length and inter-frame idle time.
   always @(negedge clk) begin
      if (!rst_a_n) begin
         a_in_pulse = 0; a_in_hi = 0; a_in_frame = 0; a_gap_track = 0; a_prev_done = 0;
      end else begin
         if (a_prev_done) check("a_busy_after_done", a_if.busy, 0);
         if (a_if.dout) begin
            if (!a_in_hi) begin
               if (a_in_pulse) end_pulse_a();
               if (a_gap_track) begin a_last_idle = a_idle; a_gap_track = 0; end
               if (!a_in_frame) begin
                  a_in_frame = 1; a_frame_len = 0; a_ones = 0; a_rise_cyc = cyc;
               end
               a_in_pulse = 1; a_in_hi = 1; a_hi = 0; a_lo = 0;
            end
            a_hi++;
         end else if (a_in_pulse) begin
            a_in_hi = 0;
            a_lo++;
         end else if (a_gap_track && !a_if.busy) begin
            a_idle++;
         end
         if (a_in_frame) a_frame_len++;
         if (a_if.frame_done) begin
            if (a_in_pulse) end_pulse_a();
            a_in_pulse = 0; a_in_hi = 0;
            check("a_busy_at_done", a_if.busy, 1);
            check("a_frame_len", a_frame_len, FRAME_A);
            a_in_frame = 0; a_frames++; a_gap_track = 1; a_idle = 0;
         end
         a_prev_done = a_if.frame_done;
      end
   end

   // ---------------- frame model for instance B ----------------
   logic [23:0] b_model [3];
   logic [71:0] b_bits;
   int b_hi, b_nbits, b_frames = 0, b_last_done = -1, b_first_rise = -1, b_rel_cyc;
   bit b_in_hi, b_in_frame, b_prev_done;

   // Decode B's frames into bits and check contents, period and done width.
   always @(negedge clk) begin
      if (!rst_b_n) begin
         b_in_hi = 0; b_in_frame = 0; b_prev_done = 0;
      end else begin
         if (b_if.dout) begin
            if (!b_in_hi) begin
               b_in_hi = 1; b_hi = 0;
               if (!b_in_frame) begin
                  b_in_frame = 1; b_bits = '0; b_nbits = 0;
                  if (b_first_rise < 0) b_first_rise = cyc;
               end
            end
            b_hi++;
         end else if (b_in_hi) begin
            b_in_hi = 0;
            b_bits  = {b_bits[70:0], (b_hi > 15)};
            b_nbits++;
         end
         if (b_if.frame_done) begin
            if (b_prev_done) check("b_done_width", 2, 1);
            check("b_nbits", b_nbits, 72);
            check("b_frame_data", b_bits, {b_model[0], b_model[1], b_model[2]});
            if (b_last_done >= 0) check("b_period", cyc - b_last_done, FRAME_B + 1);
            b_last_done = cyc; b_frames++; b_in_frame = 0;
         end
         b_prev_done = b_if.frame_done;
      end
   end

   // ---------------- stimulus helpers ----------------
   int a_show_cyc;

   task automatic wr_a(input logic addr, input logic [23:0] d);
      @(posedge clk); #1;
      a_if.wr_en = 1'b1; a_if.wr_addr = addr; a_if.wr_data = d;
      a_model[addr] = d;
      @(posedge clk); #1;
      a_if.wr_en = 1'b0;
   endtask

   task automatic show_a();
      @(posedge clk); #1;
      a_if.show = 1'b1; a_show_cyc = cyc;
      @(posedge clk); #1;
      a_if.show = 1'b0;
   endtask

   task automatic wait_a(input int target, input int budget);
      for (int i = 0; i < budget && a_frames < target; i++) @(negedge clk);
      check("a_frames_reached", a_frames, target);
   endtask

   vec_t vecs [3];

   initial begin
      int f0, fb, hits;
      vecs[0] = '{p0: 24'h800001, p1: 24'h000000, ones: 2};
      vecs[1] = '{p0: 24'hFFFFFF, p1: 24'h000000, ones: 24};
      vecs[2] = '{p0: 24'h5A5A5A, p1: 24'h0000FF, ones: 20};
      for (int i = 0; i < 2; i++) a_model[i] = INIT;
      for (int i = 0; i < 3; i++) b_model[i] = INIT;
      a_if.wr_en = 1'b0; a_if.wr_addr = '0; a_if.wr_data = '0; a_if.show = 1'b0;
      b_if.wr_en = 1'b0; b_if.wr_addr = '0; b_if.wr_data = '0; b_if.show = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("a_reset_dout", a_if.dout, 0);
      check("a_reset_busy", a_if.busy, 0);
      check("a_reset_done", a_if.frame_done, 0);
      check("b_reset_busy", b_if.busy, 0);
      rst_a_n = 1'b1; rst_b_n = 1'b1; b_rel_cyc = cyc;
      repeat (5) @(posedge clk);
      #1;
      check("a_idle_busy", a_if.busy, 0);
      check("b_first_rise", b_first_rise - b_rel_cyc, 1);

      // Table-driven frames.
      for (int v = 0; v < 3; v++) begin
         wr_a(1'b0, vecs[v].p0);
         wr_a(1'b1, vecs[v].p1);
         f0 = a_frames;
         show_a();
         push_pixel(a_model[0], 1'b0);
         push_pixel(a_model[1], 1'b1);
         wait_a(f0 + 1, FRAME_A + 100);
         check("a_show_latency", a_rise_cyc - a_show_cyc, 2);
         check("a_ones", a_ones, vecs[v].ones);
         check("a_queue_empty", exp_q.size(), 0);
      end

      // Pending request: second show mid-frame, third coalesced.
      f0 = a_frames;
      show_a();
      push_pixel(a_model[0], 1'b0); push_pixel(a_model[1], 1'b1);
      repeat (1000) @(posedge clk);
      show_a();
      push_pixel(a_model[0], 1'b0); push_pixel(a_model[1], 1'b1);
      repeat (1000) @(posedge clk);
      show_a();
      wait_a(f0 + 2, 2 * FRAME_A + 200);
      check("a_idle_between", a_last_idle, 1);
      repeat (4000) @(posedge clk);
      #1;
      check("a_coalesced_frames", a_frames, f0 + 2);
      check("a_queue_empty_pend", exp_q.size(), 0);
      check("a_busy_after_pend", a_if.busy, 0);

      // Write to a pixel not yet loaded lands in the current frame.
      wr_a(1'b0, 24'h0F00F0);
      wr_a(1'b1, 24'h000000);
      f0 = a_frames;
      show_a();
      push_pixel(a_model[0], 1'b0);
      repeat (150) @(posedge clk);
      wr_a(1'b1, 24'hFFFFFF);
      push_pixel(a_model[1], 1'b1);
      wait_a(f0 + 1, FRAME_A + 100);
      check("a_midframe_ones", a_ones, 32);
      check("a_queue_empty_mid", exp_q.size(), 0);

      // Reset 500 cycles into a frame.
      wr_a(1'b0, 24'h123456);
      wr_a(1'b1, 24'h654321);
      show_a();
      push_pixel(a_model[0], 1'b0); push_pixel(a_model[1], 1'b1);
      repeat (501) @(posedge clk);
      #1;
      rst_a_n = 1'b0;
      #1;
      check("a_abort_dout", a_if.dout, 0);
      check("a_abort_busy", a_if.busy, 0);
      check("a_abort_done", a_if.frame_done, 0);
      exp_q.delete();
      for (int i = 0; i < 2; i++) a_model[i] = INIT;
      f0 = a_frames;
      repeat (3) @(posedge clk);
      #1;
      rst_a_n = 1'b1;
      hits = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (a_if.dout || a_if.busy) hits++;
      end
      check("a_quiet_after_reset", hits, 0);
      check("a_no_done_on_abort", a_frames, f0);
      show_a();
      push_pixel(a_model[0], 1'b0); push_pixel(a_model[1], 1'b1);
      wait_a(f0 + 1, FRAME_A + 100);
      check("a_init_ones", a_ones, 8);
      check("a_queue_empty_init", exp_q.size(), 0);

      // Instance B: out-of-range write ignored, in-range write applied.
      for (int i = 0; i < FRAME_B + 100 && !b_if.frame_done; i++) @(negedge clk);
      check("b_sync", b_if.frame_done, 1);
      @(posedge clk); #1;
      fb = b_frames;
      b_if.wr_en = 1'b1; b_if.wr_addr = 2'd3; b_if.wr_data = 24'hFFFFFF;
      @(posedge clk); #1;
      b_if.wr_addr = 2'd2; b_if.wr_data = 24'h123456; b_model[2] = 24'h123456;
      @(posedge clk); #1;
      b_if.wr_en = 1'b0;
      for (int i = 0; i < 2 * FRAME_B + 200 && b_frames < fb + 2; i++) @(negedge clk);
      check("b_frames_reached", b_frames, fb + 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
